alu_pipe_nbits: RTL and testbench
=================================

Name: alu_pipe_nbits

Overview:
- Parametrised, pipelined successor to the 16-bit CLA ALU. Operand width is generalised to WIDTH, built from 16-bit slices.
- Each pipeline stage computes one 16-bit slice with the existing 16-bit slice ALU. The carry between slices is registered, so the clock rate does not depend on WIDTH.
- Adds a valid/ready handshake with backpressure, an ID tag passthrough and result flags. It sits between the operand-issue logic and the writeback path.

Parameters:
- WIDTH, 64, operand/result width. Must be a multiple of 16 and at least 16; elaboration fails otherwise.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- STAGES, WIDTH/16, derived and not overridable. Equals the number of slices, which is also the latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in into slice 0.
- S  in  4  function select, same encoding as the 4/16-bit ALUs.
- M  in  1  1 = logic mode, 0 = arithmetic mode.
- tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer takes the result this cycle.
- s  out  WIDTH  result.
- co  out  1  carry out of the top slice; 0 when M=1.
- zero  out  1  s == 0.
- ovf  out  1  signed overflow: carry into the MSB XOR co. Forced to 0 when M=1.
- out_tag  out  TAG_W  tag of the presented result.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall, combinational.
  - While stalled, every stage register holds, and out_* stay stable until accepted.
- Pipeline structure:
  - Stage k (0..STAGES-1) computes slice k (bits 16k+15..16k) from a carried copy of a, b, S, M, tag.
  - Slice k's carry-in is ci for k=0, otherwise the registered carry-out of stage k-1.
  - Each stage registers: its result slice, its carry, the already-computed lower slices, the not-yet-used upper operand slices, S, M, tag and a valid bit.
  - Operand slices already consumed are dropped from the stage registers; this is optional, but results must not change.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid, absent stalls.
  - Throughput is 1 op/cycle when out_ready is held high.
- Logic mode (M=1): slices are independent; carries are ignored; co=0, ovf=0.
- Results are bit-identical to the combinational 16-bit ALU for WIDTH=16, and to a WIDTH-bit ripple of 16-bit slices in general.
- zero and ovf are computed in the final stage from the full assembled result and registered with s.
- Reset:
  - Clears every stage valid bit (out_valid=0) and all data, carry, flag and tag registers (s=0, co=0, zero=0, ovf=0, out_tag=0).
  - in_ready is 1 during and after reset; it cannot be 0 because out_valid=0.
  - Reset mid-operation discards all in-flight ops. Nothing issued before reset is ever presented.
- Bubbles: if in_valid=0 on a non-stalled cycle, a bubble (valid=0) enters stage 0. Bubbles advance like ops and are never presented.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Ops are presented strictly in issue order; no reordering, no drops.

Decomposition:
- Package alu_pipe_pkg holds:
  - SLICE_W=16.
  - Function-select localparams for logic XOR (S=0110, M=1) and arithmetic add (S=1001, M=0).
  - A packed stage-register struct/typedef: valid, S, M, tag, carry, result bits, remaining operand bits.
- One natural sub-module, alu_pipe_stage: one slice ALU (instance of the existing alu_16bits) plus its stage register and stall enable. The top generate-loops STAGES instances and derives the flags.

Test Plan:
- Reset/idle: assert rst for 2 cycles with in_valid=1 → out_valid=0, s=0, in_ready=1; no result appears within 10 cycles after reset deasserts with in_valid=0.
- Cross-slice carry, WIDTH=64: a=64'h0000_0000_FFFF_FFFF, b=1, ci=0, S=1001, M=0 → after exactly 4 cycles s=64'h0000_0001_0000_0000, co=0, zero=0, ovf=0.
- Full wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, add → s=0, co=1, zero=1, ovf=0. Also a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → ovf=1, co=0.
- Logic mode: a=64'hF0F0_..., b=64'hFF00_..., S=0110, M=1, ci=1 → s=64'h0FF0_..., co=0, ovf=0.
- Backpressure: issue 6 back-to-back tagged ops (tags 0..5) while out_ready toggles 1,0,0,1,... → results appear in tag order, values and flags stable during stall cycles, in_ready low exactly while out_valid && !out_ready, none lost or duplicated.
- Reset mid-flight: issue 3 ops, assert rst on cycle 2 → none of the 3 is ever presented; an op issued after reset completes normally with latency STAGES.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared constants and stage-register control fields for the pipelined slice ALU.
package alu_pipe_pkg;

    localparam int SLICE_W = 16;

    // Function selects used most often by the issue logic.
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic       M_XOR = 1'b1;
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic       M_ADD = 1'b0;

    // Control portion of a stage register. The tag, result and operand fields
    // depend on the block parameters, so each stage wraps this struct in its
    // own full stage_t.
    typedef struct packed {
        logic       valid;
        logic [3:0] sel;
        logic       m;
        logic       carry;
    } stage_ctrl_t;

    // Carry handed to the next slice; logic mode never propagates a carry.
    function automatic logic stage_carry(input logic m, input logic slice_co);
        return m ? 1'b0 : slice_co;
    endfunction

endpackage

// File: rtl/alu_16bits.sv
// 16-bit slice ALU with 74181-style function select.
// Arithmetic mode computes X + Y + ci, logic mode returns ~(X ^ Y), where
// X and Y are operand terms picked by the S bits.
module alu_16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    input  logic [3:0]  S,
    input  logic        M,
    output logic [15:0] s,
    output logic        co,
    output logic        c15
);

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] lo;
    logic        msb;

    assign x = a | (b & {16{S[0]}}) | (~b & {16{S[1]}});
    assign y = (a & ~b & {16{S[2]}}) | (a & b & {16{S[3]}});

    // The low 15 bits are summed separately so the carry into bit 15 is
    // visible for signed-overflow detection.
    assign lo  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'd0, ci};
    assign msb = x[15] ^ y[15] ^ lo[15];

    // Select between logic and arithmetic results
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        s   = ~(x ^ y);
        co  = 1'b0;
        c15 = 1'b0;
        if (!M) begin
            s   = {msb, lo[14:0]};
            co  = (x[15] & y[15]) | (lo[15] & (x[15] ^ y[15]));
            c15 = lo[15];
        end
    end

endmodule

// File: rtl/alu_pipe_stage.sv
// One pipeline stage: computes slice K of the result and registers it with
// the carried operation state. Holds its register while en is low.
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4,
    parameter int K     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  stage_ctrl_t       up_ctrl,
    input  logic [TAG_W-1:0]  up_tag,
    input  logic [WIDTH-1:0]  up_res,
    input  logic [WIDTH-1:0]  up_a,
    input  logic [WIDTH-1:0]  up_b,
    output stage_ctrl_t       ctrl,
    output logic [TAG_W-1:0]  tag,
    output logic [WIDTH-1:0]  res,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  res_next,
    output logic              co_next,
    output logic              c15_next
);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t      d;
    stage_t      q;
    logic [15:0] slice_s;
    logic        slice_co;
    logic        slice_c15;

    alu_16bits u_slice (
        .a   (up_a[K*SLICE_W +: SLICE_W]),
        .b   (up_b[K*SLICE_W +: SLICE_W]),
        .ci  (up_ctrl.carry),
        .S   (up_ctrl.sel),
        .M   (up_ctrl.m),
        .s   (slice_s),
        .co  (slice_co),
        .c15 (slice_c15)
    );

    // Merge this slice's result into the carried state
    always_comb begin
        d                          = '0;
        d.ctrl                     = up_ctrl;
        d.ctrl.carry               = stage_carry(up_ctrl.m, slice_co);
        d.tag                      = up_tag;
        d.res                      = up_res;
        d.res[K*SLICE_W +: SLICE_W] = slice_s;
        d.a                        = up_a;
        d.b                        = up_b;
    end

    // Stage register: clear on reset, hold while the pipe is stalled
    always_ff @(posedge clk) begin
        // NOTE: data fields are cleared along with valid so out_* read zero after reset.
        if (rst) begin
            q <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples its upstream's pre-edge value.
            q <= d;
        end
    end

    assign ctrl     = q.ctrl;
    assign tag      = q.tag;
    assign res      = q.res;
    assign a        = q.a;
    assign b        = q.b;
    assign res_next = d.res;
    assign co_next  = d.ctrl.carry;
    assign c15_next = slice_c15;

endmodule

// File: rtl/alu_pipe_nbits.sv
// Pipelined WIDTH-bit ALU built from 16-bit slices, one slice per stage, with
// a valid/ready handshake, tag passthrough and zero/overflow flags.
module alu_pipe_nbits
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             zero,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STAGES = WIDTH / SLICE_W;

    generate
        if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
            $error("alu_pipe_nbits: WIDTH must be a positive multiple of 16");
        end
    endgenerate

    // Index 0 is the issue side; index k+1 is the output of stage k.
    stage_ctrl_t      ctrl_w     [0:STAGES];
    logic [TAG_W-1:0] tag_w      [0:STAGES];
    logic [WIDTH-1:0] res_w      [0:STAGES];
    logic [WIDTH-1:0] a_w        [0:STAGES];
    logic [WIDTH-1:0] b_w        [0:STAGES];
    logic [WIDTH-1:0] res_next_w [0:STAGES-1];
    logic             co_next_w  [0:STAGES-1];
    logic             c15_next_w [0:STAGES-1];

    logic stall;
    logic en;

    // A single global stall freezes every stage while the result waits.
    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = !stall;

    assign ctrl_w[0] = '{valid: in_valid, sel: S, m: M, carry: ci};
    assign tag_w[0]  = tag;
    assign res_w[0]  = '0;
    assign a_w[0]    = a;
    assign b_w[0]    = b;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            alu_pipe_stage #(
                .WIDTH (WIDTH),
                .TAG_W (TAG_W),
                .K     (k)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .up_ctrl  (ctrl_w[k]),
                .up_tag   (tag_w[k]),
                .up_res   (res_w[k]),
                .up_a     (a_w[k]),
                .up_b     (b_w[k]),
                .ctrl     (ctrl_w[k+1]),
                .tag      (tag_w[k+1]),
                .res      (res_w[k+1]),
                .a        (a_w[k+1]),
                .b        (b_w[k+1]),
                .res_next (res_next_w[k]),
                .co_next  (co_next_w[k]),
                .c15_next (c15_next_w[k])
            );
        end
    endgenerate

    // Flags come from the fully assembled result entering the last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (en) begin
            zero <= (res_next_w[STAGES-1] == '0);
            ovf  <= !ctrl_w[STAGES-1].m && (c15_next_w[STAGES-1] ^ co_next_w[STAGES-1]);
        end
    end

    assign out_valid = ctrl_w[STAGES].valid;
    assign s         = res_w[STAGES];
    assign co        = ctrl_w[STAGES].carry;
    assign out_tag   = tag_w[STAGES];

endmodule

// File: tb/tb_alu_pipe_nbits.sv
// Self-checking bench for alu_pipe_nbits (WIDTH=64): directed corner cases plus
// randomized traffic checked against a whole-word reference model.
module tb_alu_pipe_nbits;

    localparam int W      = 64;
    localparam int TW     = 4;
    localparam int STAGES = W / 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic [3:0]    S;
    logic          M;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          co;
    logic          zero;
    logic          ovf;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    alu_pipe_nbits #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .S         (S),
        .M         (M),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .zero      (zero),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [W-1:0]  s;
        logic          co;
        logic          zero;
        logic          ovf;
        logic [TW-1:0] tag;
        int            age;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_out    = 0;
    bit   model_ok = 1'b0;

    // Reference: the 74181 function table evaluated over the whole word.
    function automatic exp_t ref_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                    input logic cin, input logic [3:0] sel,
                                    input logic m, input logic [TW-1:0] t);
        exp_t       r;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] f;
        logic [W:0]   sum;
        logic [W-1:0] lo;
        x = '0;
        y = '0;
        f = '0;
        r.co  = 1'b0;
        r.ovf = 1'b0;
        if (m) begin
            case (sel)
                4'd0:  f = ~aa;
                4'd1:  f = ~(aa | bb);
                4'd2:  f = ~aa & bb;
                4'd3:  f = '0;
                4'd4:  f = ~(aa & bb);
                4'd5:  f = ~bb;
                4'd6:  f = aa ^ bb;
                4'd7:  f = aa & ~bb;
                4'd8:  f = ~aa | bb;
                4'd9:  f = ~(aa ^ bb);
                4'd10: f = bb;
                4'd11: f = aa & bb;
                4'd12: f = '1;
                4'd13: f = aa | ~bb;
                4'd14: f = aa | bb;
                default: f = aa;
            endcase
        end else begin
            case (sel)
                4'd0:  begin x = aa;       y = '0;        end
                4'd1:  begin x = aa | bb;  y = '0;        end
                4'd2:  begin x = aa | ~bb; y = '0;        end
                4'd3:  begin x = '1;       y = '0;        end
                4'd4:  begin x = aa;       y = aa & ~bb;  end
                4'd5:  begin x = aa | bb;  y = aa & ~bb;  end
                4'd6:  begin x = aa;       y = ~bb;       end
                4'd7:  begin x = aa & ~bb; y = '1;        end
                4'd8:  begin x = aa;       y = aa & bb;   end
                4'd9:  begin x = aa;       y = bb;        end
                4'd10: begin x = aa | ~bb; y = aa & bb;   end
                4'd11: begin x = aa & bb;  y = '1;        end
                4'd12: begin x = aa;       y = aa;        end
                4'd13: begin x = aa | bb;  y = aa;        end
                4'd14: begin x = aa | ~bb; y = aa;        end
                default: begin x = '1;     y = aa;        end
            endcase
            sum   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
            lo    = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {{(W-1){1'b0}}, cin};
            f     = sum[W-1:0];
            r.co  = sum[W];
            r.ovf = lo[W-1] ^ sum[W];
        end
        r.s    = f;
        r.zero = (f == '0);
        r.tag  = t;
        r.age  = 1;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then advance the model.
    task automatic tick(output bit accepted);
        bit exp_v;
        bit exp_stall;
        #1;
        exp_v     = (q.size() > 0) && (q[0].age == STAGES);
        exp_stall = exp_v && !out_ready;
        accepted  = model_ok && !rst && in_valid && !exp_stall;
        if (model_ok) begin
            check("out_valid", W'(out_valid), W'(exp_v));
            check("in_ready", W'(in_ready), W'(!exp_stall));
            if (exp_v) begin
                check("s", s, q[0].s);
                check("co", W'(co), W'(q[0].co));
                check("zero", W'(zero), W'(q[0].zero));
                check("ovf", W'(ovf), W'(q[0].ovf));
                check("out_tag", W'(out_tag), W'(q[0].tag));
            end
        end
        if (out_valid === 1'b1 && out_ready) n_out++;
        @(posedge clk);
        if (rst) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (exp_v && out_ready) void'(q.pop_front());
            if (!exp_stall) begin
                foreach (q[i]) q[i].age++;
                if (in_valid) q.push_back(ref_op(a, b, ci, S, M, tag));
            end
        end
        @(negedge clk);
    endtask

    task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                            input logic dci, input logic [3:0] dsel, input logic dm,
                            input logic [TW-1:0] dtag, input logic [W-1:0] es,
                            input logic eco, input logic ez, input logic eovf);
        bit acc;
        a = da; b = db; ci = dci; S = dsel; M = dm; tag = dtag;
        in_valid = 1'b1; out_ready = 1'b1;
        tick(acc);
        check({name, "_accept"}, W'(acc), W'(1'b1));
        in_valid = 1'b0;
        repeat (STAGES - 1) tick(acc);
        #1;
        check({name, "_latency"}, W'(out_valid), W'(1'b1));
        check({name, "_s"}, s, es);
        check({name, "_co"}, W'(co), W'(eco));
        check({name, "_zero"}, W'(zero), W'(ez));
        check({name, "_ovf"}, W'(ovf), W'(eovf));
        check({name, "_tag"}, W'(out_tag), W'(dtag));
    endtask

    initial begin
        bit acc;
        int issued;
        int n_start;
        int budget;

        // Reset with in_valid high for two cycles
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1; ci = 1'b0; S = S_ADD_TB(); M = 1'b0; tag = 4'h3;
        tick(acc);
        tick(acc);
        #1;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_s", s, '0);
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_co", W'(co), W'(1'b0));
        check("rst_out_tag", W'(out_tag), W'(4'h0));
        rst = 1'b0; in_valid = 1'b0;
        n_start = n_out;
        repeat (10) tick(acc);
        check("idle_no_result", W'(n_out - n_start), W'(0));

        // Directed corner cases
        directed("carry_x_slice", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 4'b1001, 1'b0, 4'h1,
                 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        directed("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'b1001, 1'b0, 4'h2,
                 64'h0, 1'b1, 1'b1, 1'b0);
        directed("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'b1001, 1'b0, 4'h3,
                 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        directed("logic_xor", 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 4'b0110, 1'b1,
                 4'h4, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        directed("sub_borrow", 64'h0, 64'h0, 1'b0, 4'b0110, 1'b0, 4'h5,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick(acc);

        // Backpressure: six tagged ops while out_ready cycles 1,0,0
        issued = 0; n_start = n_out; budget = 0;
        while ((issued < 6 || q.size() > 0) && budget < 200) begin
            in_valid  = (issued < 6);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            ci = 1'(issued); S = 4'b1001; M = 1'b0; tag = TW'(issued);
            out_ready = (budget % 3 == 0);
            tick(acc);
            if (acc) issued++;
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_issued", W'(issued), W'(6));
        check("bp_presented", W'(n_out - n_start), W'(6));
        tick(acc);

        // Reset mid-flight discards in-flight ops
        n_start = n_out;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
            S = 4'b1001; M = 1'b0; tag = TW'(8 + i);
            tick(acc);
        end
        in_valid = 1'b0; rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        repeat (10) tick(acc);
        check("midrst_dropped", W'(n_out - n_start), W'(0));
        directed("post_reset", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 4'b1001, 1'b0,
                 4'hA, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        tick(acc);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: a = '1;
                1: a = {32'h7FFF_FFFF, $urandom};
                default: a = {$urandom, $urandom};
            endcase
            b   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : {$urandom, $urandom};
            ci  = 1'($urandom);
            S   = 4'($urandom);
            M   = 1'($urandom);
            tag = TW'($urandom);
            tick(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (STAGES + 2) tick(acc);
        check("drain_empty", W'(q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [3:0] S_ADD_TB();
        return 4'b1001;
    endfunction

endmodule
